truth_table_scanner: RTL
========================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have one parameter: SETTLE, default 1, cycles sel is held before y_in is sampled (legal 1..15).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port clk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be: input, 1 bit, synchronous active-low reset.
REQ-005 Port start SHALL be: input, 1 bit, scan request, sampled on a rising edge.
REQ-006 Port expected SHALL be: input, 8 bits, reference truth table, bit i = required output for sel = i.
REQ-007 Port y_in SHALL be: input, 1 bit, output of the downstream combinational mux under test.
REQ-008 Port sel SHALL be: output, 3 bits, {A,B,C} select/input combination driven to the mux, A = MSB.
REQ-009 Port busy SHALL be: output, 1 bit, high while a scan is in progress.
REQ-010 Port done SHALL be: output, 1 bit, single-cycle pulse when a scan completes.
REQ-011 Port table_out SHALL be: output, 8 bits, captured truth table, bit i = y_in sampled with sel = i.
REQ-012 Port match SHALL be: output, 1 bit, high when the last completed table_out equals the expected value latched at start.

Function
REQ-013 The block SHALL implement the states IDLE, DRIVE, SAMPLE and DONE, all registered.
REQ-014 In IDLE, start = 1 at an edge SHALL do all of the following: latch expected into an internal register, clear the capture shift register, set sel = 0, and enter DRIVE.
REQ-015 In DRIVE, the block SHALL hold sel stable for exactly SETTLE cycles using a settle counter, then enter SAMPLE.
REQ-016 In SAMPLE (one cycle), the block SHALL write y_in into capture bit sel. If sel != 7 it SHALL increment sel and return to DRIVE; if sel == 7 it SHALL enter DONE with sel unchanged.
REQ-017 In DONE (one cycle), the block SHALL do all of the following: assert done, load table_out from the capture register, load match = (capture == latched expected), set sel = 0, and return to IDLE.
REQ-018 Each input combination SHALL take exactly SETTLE+1 cycles. If start is sampled at edge k, DONE SHALL be entered at edge k+1+8*(SETTLE+1).
REQ-019 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-020 The block SHALL ignore start while busy = 1 or in DONE; no restart and no queuing.
REQ-021 table_out and match SHALL hold their values from DONE until the next DONE; they SHALL NOT change mid-scan.
REQ-022 The block SHALL NOT sample expected after start acceptance; changes to expected mid-scan SHALL have no effect.
REQ-023 sel SHALL be 0 whenever the state is IDLE.
REQ-024 The block SHALL never emit sel values out of order; sel SHALL follow the sequence 0,1,...,7 with no skips or wrap within one scan.

Reset
REQ-025 While rst_n = 0 at an edge, the block SHALL set: state = IDLE, sel = 0, busy = 0, done = 0, table_out = 8'h00, match = 0, settle counter and capture register = 0, and the latched expected value = 0.
REQ-026 rst_n = 0 mid-scan SHALL abort the scan. No done pulse SHALL occur and table_out SHALL read 8'h00 after reset.
REQ-027 If start = 1 and rst_n = 0 at the same edge, reset SHALL win, and the block SHALL not begin a scan until start is sampled again with rst_n = 1.

Verification
REQ-028 Scenario V1 (basic scan): bench models mux data d0..d7 = 1,0,0,0,1,1,1,0; SETTLE = 1; expected = 8'h71; pulse start -> done exactly 17 cycles after the start edge, table_out = 8'h71, match = 1.
REQ-029 Scenario V2 (mismatch): bench models y = A ? ~(B^C) : (B^C); expected = 8'h00 -> table_out = 8'h96, match = 0.
REQ-030 Scenario V3 (settle timing): SETTLE = 3 -> each sel value stable for 4 cycles; done 33 cycles after start; bench checks the sel sequence 0..7.
REQ-031 Scenario V4 (ignored inputs): start held high throughout a scan and expected changed mid-scan -> exactly one done pulse; match uses the expected value latched at start; a new scan starts only on the first IDLE edge with start = 1.
REQ-032 Scenario V5 (reset mid-scan): rst_n low for 1 cycle at sel = 4 -> busy = 0, sel = 0, table_out = 8'h00, no done pulse; a subsequent scan completes normally.
REQ-033 Scenario V6 (hold): after a completed scan, bench changes y_in and expected while idle -> table_out and match remain unchanged.

Source files
------------

// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and its driver: scan request/reference in,
// mux select out, mux response in, captured table and status out.
interface truth_table_scanner_if;
  logic       start;
  logic [7:0] expected;
  logic       y_in;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       match;

  modport master (
    output start, expected, y_in,
    input  sel, busy, done, table_out, match
  );

  modport slave (
    input  start, expected, y_in,
    output sel, busy, done, table_out, match
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks sel through 0..7, lets the mux under test settle for SETTLE cycles per
// combination, captures y_in into a table and compares it with a reference latched at start.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_scanner_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [7:0] capture;
  logic [7:0] exp_lat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      settle_cnt    <= 4'd0;
      capture       <= 8'h00;
      exp_lat       <= 8'h00;
      bus.sel       <= 3'd0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.table_out <= 8'h00;
      bus.match     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            exp_lat    <= bus.expected;
            capture    <= 8'h00;
            settle_cnt <= 4'd0;
            bus.sel    <= 3'd0;
            bus.busy   <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          capture[bus.sel] <= bus.y_in;
          if (bus.sel != 3'd7) begin
            bus.sel <= bus.sel + 3'd1;
            state   <= DRIVE;
          end else begin
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          // Results publish on the exit edge so table_out/match never move mid-scan.
          bus.done      <= 1'b1;
          bus.table_out <= capture;
          bus.match     <= (capture == exp_lat);
          bus.sel       <= 3'd0;
          state         <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.sel  <= 3'd0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
